axis_requant: RTL

//  Downstream of the systolic array: consumes its AXI-Stream output (Rows lanes x WidthY
//  per beat, Cols beats per tile, last on beat Cols-1; beat k carries column k) and

---
 rtl/sa_pkg.sv | 37 +++
 rtl/axis_requant_if.sv | 37 +++
 rtl/requant_lane.sv | 42 ++++
 rtl/axis_requant.sv | 138 +++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// sa_pkg: arithmetic helpers shared by the systolic array and the stages after it.
//   imax      - integer max, used to size internal datapaths at elaboration
//   sat_s     - saturate a wide signed value to a narrower signed width
//   rnd_const - round-half-up constant added before an arithmetic right shift
//   shr_rnd   - rounding arithmetic right shift (rnd_const + >>>)
// All helpers work on a 64-bit signed carrier. Callers sign-extend in and truncate out.
package sa_pkg;

    localparam int WideW = 64;
    typedef logic signed [WideW-1:0] wide_t;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Clamp v to [-2^(w-1), 2^(w-1)-1].
    function automatic wide_t sat_s(input wide_t v, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Half an LSB of the shifted result. Zero when there is no shift.
    function automatic wide_t rnd_const(input int sh);
        if (sh <= 0) return '0;
        return wide_t'(1) <<< (sh - 1);
    endfunction

    function automatic wide_t shr_rnd(input wide_t v, input int sh);
        return (v + rnd_const(sh)) >>> sh;
    endfunction

endpackage

// File: rtl/axis_requant_if.sv
// axis_requant_if: bundle of the requantiser stream and configuration signals.
//   slave  modport : the requantiser's view (s_* and config in, m_* and err_o out)
//   master modport : the producer/consumer view (the mirror image)
// Signal names keep the block's port naming so the bundle reads like the port list.
interface axis_requant_if #(
    parameter int Rows   = 4,
    parameter int Cols   = 8,
    parameter int WidthY = 16,
    parameter int WidthB = 16,
    parameter int WidthO = 8,
    parameter int WidthS = $clog2(WidthY)
) ();

    logic                         s_valid_i;
    logic                         s_ready_o;
    logic                         s_last_i;
    logic [Rows-1:0][WidthY-1:0]  s_data_i;
    logic [Cols-1:0][WidthB-1:0]  bias_i;
    logic [WidthS-1:0]            shift_i;
    logic                         relu_i;
    logic                         m_valid_o;
    logic                         m_ready_i;
    logic                         m_last_o;
    logic [Rows-1:0][WidthO-1:0]  m_data_o;
    logic                         err_o;

    modport slave (
        input  s_valid_i, s_last_i, s_data_i, bias_i, shift_i, relu_i, m_ready_i,
        output s_ready_o, m_valid_o, m_last_o, m_data_o, err_o
    );

    modport master (
        output s_valid_i, s_last_i, s_data_i, bias_i, shift_i, relu_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_last_o, m_data_o, err_o
    );

endinterface

// File: rtl/requant_lane.sv
// requant_lane: combinational math for one lane of the requantiser.
//   Stage-1 half: x_i, bias_i, s1_shift_i -> s1_sum_o = x + bias + rounding constant
//   Stage-2 half: s2_sum_i, s2_shift_i, s2_relu_i -> s2_y_o = sat(relu(sum >>> shift))
// The two halves are independent. The parent places the pipeline register between them.
module requant_lane
    import sa_pkg::*;
#(
    parameter int WidthY   = 16,
    parameter int WidthB   = 16,
    parameter int WidthO   = 8,
    parameter int WidthS   = $clog2(WidthY),
    // Holds x + bias (one carry bit) plus the largest rounding constant
    // the shift field can express. The sum never wraps.
    parameter int WidthSum = imax(imax(WidthY, WidthB), 1 << WidthS) + 2
) (
    input  logic signed [WidthY-1:0]   x_i,
    input  logic signed [WidthB-1:0]   bias_i,
    input  logic        [WidthS-1:0]   s1_shift_i,
    output logic signed [WidthSum-1:0] s1_sum_o,
    input  logic signed [WidthSum-1:0] s2_sum_i,
    input  logic        [WidthS-1:0]   s2_shift_i,
    input  logic                       s2_relu_i,
    output logic signed [WidthO-1:0]   s2_y_o
);

    wide_t sum_w;
    wide_t t_w;

    always_comb begin
        sum_w    = wide_t'(x_i) + wide_t'(bias_i) + rnd_const(int'(s1_shift_i));
        s1_sum_o = WidthSum'(sum_w);
    end

    always_comb begin
        t_w = wide_t'(s2_sum_i) >>> s2_shift_i;
        if (s2_relu_i && (t_w < 0)) begin
            t_w = '0;
        end
        s2_y_o = WidthO'(sat_s(t_w, WidthO));
    end

endmodule

// File: rtl/axis_requant.sv
// axis_requant: requantises the systolic array's output stream.
//   clk_i, rst_i : clock and asynchronous active-high reset
//   bus (slave)  : s_valid_i/s_ready_o/s_last_i/s_data_i  input beats (beat k = column k)
//                  bias_i/shift_i/relu_i                  tile config, taken at col 0
//                  m_valid_o/m_ready_i/m_last_o/m_data_o  output beats
//                  err_o                                  sticky framing error
// The block has two stages with full valid/ready backpressure. Each lane computes
// x + bias[col], a round-half-up arithmetic right shift, an optional ReLU and
// saturation to WidthO.
module axis_requant
    import sa_pkg::*;
#(
    parameter int Rows   = 4,
    parameter int Cols   = 8,
    parameter int WidthY = 16,
    parameter int WidthB = 16,
    parameter int WidthO = 8,
    parameter int WidthS = $clog2(WidthY)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    axis_requant_if.slave   bus
);

    localparam int Stages   = 2;
    localparam int ColW     = (Cols > 1) ? $clog2(Cols) : 1;
    localparam int WidthSum = imax(imax(WidthY, WidthB), 1 << WidthS) + 2;
    localparam logic [ColW-1:0] ColLast = ColW'(Cols - 1);

    // Column tracking, captured config and the sticky error flag.
    logic [ColW-1:0]                col_q, col_d;
    logic                           err_q, err_d;
    logic [Cols-1:0][WidthB-1:0]    bias_q;
    logic [WidthS-1:0]              shift_q;
    logic                           relu_q;

    // Pipeline state
    logic [Stages:1]                vld_pipe_q;
    logic                           last1_q, last2_q;
    logic [Rows-1:0][WidthSum-1:0]  sum1_q;
    logic [WidthS-1:0]              shift1_q;
    logic                           relu1_q;
    logic [Rows-1:0][WidthO-1:0]    data2_q;

    logic                           acc, adv1, adv2, tile_start;
    logic [Cols-1:0][WidthB-1:0]    cur_tbl;
    logic [WidthB-1:0]              cur_bias;
    logic [WidthS-1:0]              cur_shift;
    logic                           cur_relu;
    logic [Rows-1:0][WidthSum-1:0]  lane_sum;
    logic [Rows-1:0][WidthO-1:0]    lane_y;

    // A stage advances when it is empty or the stage after it advances.
    assign adv2          = !vld_pipe_q[2] || bus.m_ready_i;
    assign adv1          = !vld_pipe_q[1] || adv2;
    assign bus.s_ready_o = adv1;
    assign acc           = bus.s_valid_i && adv1;

    // Beat 0 of a tile uses the live config. Later beats use the copy taken at beat 0.
    assign tile_start = (col_q == '0);
    assign cur_tbl    = tile_start ? bus.bias_i  : bias_q;
    assign cur_shift  = tile_start ? bus.shift_i : shift_q;
    assign cur_relu   = tile_start ? bus.relu_i  : relu_q;
    assign cur_bias   = cur_tbl[col_q];

    // An early last or a missing last both mean last != (col at end).
    // In either case the counter goes back to 0, so the next beat starts a new tile.
    always_comb begin
        col_d = col_q;
        err_d = err_q;
        if (acc) begin
            col_d = (bus.s_last_i || (col_q == ColLast)) ? '0 : col_q + ColW'(1);
            err_d = err_q | (bus.s_last_i != (col_q == ColLast));
        end
    end

    for (genvar r = 0; r < Rows; r++) begin : g_lane
        requant_lane #(
            .WidthY   (WidthY),
            .WidthB   (WidthB),
            .WidthO   (WidthO),
            .WidthS   (WidthS),
            .WidthSum (WidthSum)
        ) u_lane (
            .x_i        (bus.s_data_i[r]),
            .bias_i     (cur_bias),
            .s1_shift_i (cur_shift),
            .s1_sum_o   (lane_sum[r]),
            .s2_sum_i   (sum1_q[r]),
            .s2_shift_i (shift1_q),
            .s2_relu_i  (relu1_q),
            .s2_y_o     (lane_y[r])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q      <= '0;
            err_q      <= 1'b0;
            bias_q     <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            vld_pipe_q <= '0;
            last1_q    <= 1'b0;
            sum1_q     <= '0;
            shift1_q   <= '0;
            relu1_q    <= 1'b0;
            last2_q    <= 1'b0;
            data2_q    <= '0;
        end else begin
            col_q <= col_d;
            err_q <= err_d;
            if (acc && tile_start) begin
                bias_q  <= bus.bias_i;
                shift_q <= bus.shift_i;
                relu_q  <= bus.relu_i;
            end
            if (adv1) begin
                vld_pipe_q[1] <= bus.s_valid_i;
                last1_q       <= bus.s_valid_i && bus.s_last_i;
                sum1_q        <= lane_sum;
                shift1_q      <= cur_shift;
                relu1_q       <= cur_relu;
            end
            if (adv2) begin
                vld_pipe_q[2] <= vld_pipe_q[1];
                last2_q       <= vld_pipe_q[1] && last1_q;
                data2_q       <= lane_y;
            end
        end
    end

    assign bus.m_valid_o = vld_pipe_q[2];
    assign bus.m_last_o  = last2_q;
    assign bus.m_data_o  = data2_q;
    assign bus.err_o     = err_q;

endmodule
